// File: rtl/retire_rat.sv
// Retirement register alias table: committed arch->phys map, stale phys reg
// return to the free list on commit, and a one-cycle map snapshot on flush.
module retire_rat #(
    parameter int unsigned ARF_DEPTH = 32,
    parameter int unsigned PRF_DEPTH = 64,
    parameter int unsigned ARF_IDX   = $clog2(ARF_DEPTH),
    parameter int unsigned PRF_IDX   = $clog2(PRF_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit_valid,
    output logic                         commit_ready,
    input  logic                         commit_rd_we,
    input  logic [ARF_IDX-1:0]           commit_rd_arch,
    input  logic [PRF_IDX-1:0]           commit_pd,
    output logic                         fl_valid,
    output logic [PRF_IDX-1:0]           fl_stale_idx,
    input  logic                         flush,
    output logic                         restore_valid,
    output logic [ARF_DEPTH*PRF_IDX-1:0] restore_map,
    output logic [31:0]                  commit_count
);

    typedef enum logic {
        RUN,
        RESTORE
    } state_t;

    state_t               state_q, state_d;
    logic [PRF_IDX-1:0]   map_q [ARF_DEPTH];
    logic                 fl_valid_q, fl_valid_d;
    logic [PRF_IDX-1:0]   fl_stale_q, fl_stale_d;
    logic [31:0]          count_q, count_d;
    logic                 accept;
    logic                 do_write;

    // Next state, commit acceptance, and the registered free-list return.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        do_write   = 1'b0;
        fl_valid_d = 1'b0;
        fl_stale_d = fl_stale_q;
        count_d    = count_q;
        case (state_q)
            RUN: begin
                accept = commit_valid;
                if (flush) begin
                    state_d = RESTORE;
                end
            end
            RESTORE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (accept) begin
            count_d = count_q + 32'd1;
            if (commit_rd_we && (commit_rd_arch != '0)) begin
                do_write   = 1'b1;
                fl_valid_d = 1'b1;
                // Stale index is read before the same-edge map write lands.
                fl_stale_d = map_q[commit_rd_arch];
            end
        end
    end

    // State, counter and free-list registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fl_valid_q <= 1'b0;
            fl_stale_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fl_valid_q <= fl_valid_d;
            fl_stale_q <= fl_stale_d;
            count_q    <= count_d;
        end
    end

    // Committed map: identity at reset, entry 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ARF_DEPTH; i++) begin
                map_q[i] <= PRF_IDX'(i);
            end
        end else if (do_write) begin
            map_q[commit_rd_arch] <= commit_pd;
        end
    end

    // Flatten the registered table onto the snapshot bus.
    always_comb begin
        restore_map = '0;
        for (int unsigned i = 0; i < ARF_DEPTH; i++) begin
            restore_map[i*PRF_IDX +: PRF_IDX] = map_q[i];
        end
    end

    // Output drive.
    always_comb begin
        commit_ready  = (state_q == RUN);
        restore_valid = (state_q == RESTORE);
        fl_valid      = fl_valid_q;
        fl_stale_idx  = fl_stale_q;
        commit_count  = count_q;
    end

endmodule

// File: tb/tb_retire_rat.sv
// Randomized and directed bench for retire_rat against an array-based model.
module tb_retire_rat;

    localparam int ARF = 32;
    localparam int PW  = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            commit_valid;
    logic            commit_ready;
    logic            commit_rd_we;
    logic [4:0]      commit_rd_arch;
    logic [PW-1:0]   commit_pd;
    logic            fl_valid;
    logic [PW-1:0]   fl_stale_idx;
    logic            flush;
    logic            restore_valid;
    logic [ARF*PW-1:0] restore_map;
    logic [31:0]     commit_count;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int          m_map [ARF];
    bit          m_restore;
    logic [31:0] m_count;

    retire_rat #(.ARF_DEPTH(32), .PRF_DEPTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_rd_we   (commit_rd_we),
        .commit_rd_arch (commit_rd_arch),
        .commit_pd      (commit_pd),
        .fl_valid       (fl_valid),
        .fl_stale_idx   (fl_stale_idx),
        .flush          (flush),
        .restore_valid  (restore_valid),
        .restore_map    (restore_map),
        .commit_count   (commit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ARF; i++) m_map[i] = i;
        m_restore = 1'b0;
        m_count   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        commit_valid = 1'b0; commit_rd_we = 1'b0; commit_rd_arch = '0; commit_pd = '0; flush = 1'b0;
        @(posedge clk); #1;
        chk("rst_fl_valid", {63'd0, fl_valid}, 64'd0);
        chk("rst_restore_valid", {63'd0, restore_valid}, 64'd0);
        model_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", {63'd0, commit_ready}, 64'd1);
        chk("rst_count", {32'd0, commit_count}, 64'd0);
        chk("rst_fl_valid2", {63'd0, fl_valid}, 64'd0);
    endtask

    // Drive one cycle of inputs, advance a clock, compare against the model.
    task automatic step(input bit v, input bit we, input int arch, input int pd, input bit fl);
        bit accept, freed;
        int stale;
        commit_valid   = v;
        commit_rd_we   = we;
        commit_rd_arch = 5'(arch);
        commit_pd      = PW'(pd);
        flush          = fl;
        chk("ready_pre", {63'd0, commit_ready}, {63'd0, !m_restore});
        accept = v && !m_restore;
        freed  = accept && we && (arch != 0);
        stale  = m_map[arch];
        if (freed) m_map[arch] = pd;
        if (accept) m_count = m_count + 32'd1;
        m_restore = !m_restore && fl;
        @(posedge clk); #1;
        chk("fl_valid", {63'd0, fl_valid}, {63'd0, freed});
        if (freed) chk("fl_stale", {58'd0, fl_stale_idx}, 64'(stale));
        chk("restore_valid", {63'd0, restore_valid}, {63'd0, m_restore});
        chk("ready", {63'd0, commit_ready}, {63'd0, !m_restore});
        chk("count", {32'd0, commit_count}, {32'd0, m_count});
        if (m_restore) begin
            for (int i = 0; i < ARF; i++) begin
                logic [PW-1:0] e;
                e = restore_map[i*PW +: PW];
                chk($sformatf("map[%0d]", i), {58'd0, e}, 64'(m_map[i]));
            end
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Snapshot right after reset is the identity map, one cycle only.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Back-to-back commits to the same destination.
        step(1, 1, 5, 40, 0);
        step(1, 1, 5, 41, 0);

        // x0 and no-write commits only count.
        step(1, 1, 0, 33, 0);
        step(1, 0, 12, 44, 0);

        // Commit together with flush; during RESTORE the commit and the flush are ignored.
        step(1, 1, 7, 50, 1);
        step(1, 1, 9, 60, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("map9_identity", {58'd0, restore_map[9*PW +: PW]}, 64'd9);
        chk("map0_zero", {58'd0, restore_map[0 +: PW]}, 64'd0);
        step(0, 0, 0, 0, 0);

        // Fill the whole map from reset, then reset with a free pending.
        do_reset();
        for (int k = 0; k < 32; k++) begin
            int rd;
            rd = (k < 31) ? k + 1 : 1;
            step(1, 1, rd, 32 + k, 0);
        end
        commit_valid = 1'b1; commit_rd_we = 1'b1; commit_rd_arch = 5'd3; commit_pd = 6'd20;
        do_reset();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Random traffic with occasional flushes and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                     $urandom_range(0, 9) == 0);
            end
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
